// File: rtl/sub_32bit_serial.sv
// Serial subtractor: diff = a - b - bin, one SLICE-bit slice per clock, LSB slice first.
// Result valid WIDTH/SLICE clocks after accept; held in DONE until out_ready, then one idle bubble.
module sub_32bit_serial #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = $clog2(NSL);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic [SLICE:0]   slice_res;
    logic             last;
    logic             accept;
    logic             handoff;

    assign accept  = in_valid & in_ready;
    assign handoff = out_valid & out_ready;
    assign last    = (cnt == CW'(NSL - 1));

    // Top bit of the widened result is the slice borrow-out.
    assign slice_res = {1'b0, a_q[cnt*SLICE +: SLICE]}
                     - {1'b0, b_q[cnt*SLICE +: SLICE]}
                     - {{SLICE{1'b0}}, borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (last) state_nxt = DONE;
            DONE:    if (handoff) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= bin;
            cnt    <= '0;
        end else if (state == BUSY) begin
            diff[cnt*SLICE +: SLICE] <= slice_res[SLICE-1:0];
            borrow                   <= slice_res[SLICE];
            cnt                      <= cnt + 1'b1;
            if (last) begin
                bout <= slice_res[SLICE];
                ovf  <= (a_q[MSB] != b_q[MSB]) & (slice_res[SLICE-1] != a_q[MSB]);
            end
        end
    end
endmodule
